// File: rtl/text_overlay.sv
// Text overlay for a VGA pixel stream: a 16-character message buffer rendered
// through an external glyph ROM and composited over the background pixels.
module text_overlay #(
    parameter logic [9:0]  TEXT_X0  = 10'd0,
    parameter logic [9:0]  TEXT_Y0  = 10'd0,
    parameter logic [15:0] FG_COLOR = 16'hFFFF
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] pix_data_in,
    input  logic        frame_start,
    input  logic        blink_en,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [4:0]  wr_char,
    input  logic        clr_req,
    output logic        clr_done,
    output logic [4:0]  glyph_letter,
    output logic [3:0]  glyph_x,
    output logic [3:0]  glyph_y,
    input  logic        glyph_bit,
    output logic [15:0] pix_data
);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t      state;
    logic [4:0]  buffer [16];
    logic [3:0]  clr_cnt;
    logic [4:0]  blink_cnt;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        in_box;
    logic        in_box_d1;
    logic [15:0] pix_data_in_d1;
    logic        visible;

    // A pixel left of / above the box wraps dx/dy to a large value; the explicit
    // >= compares reject it so only the unwrapped offsets are range-checked.
    always_comb begin
        dx      = pix_x - TEXT_X0;
        dy      = pix_y - TEXT_Y0;
        in_box  = (pix_x >= TEXT_X0) && (dx < 10'd256) &&
                  (pix_y >= TEXT_Y0) && (dy < 10'd16);
        visible = blink_en ? ~blink_cnt[4] : 1'b1;
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            glyph_x        <= 4'd0;
            glyph_y        <= 4'd0;
            glyph_letter   <= 5'd31;
            in_box_d1      <= 1'b0;
            pix_data_in_d1 <= 16'h0000;
            pix_data       <= 16'h0000;
        end else begin
            glyph_x        <= dx[3:0];
            glyph_y        <= dy[3:0];
            glyph_letter   <= in_box ? buffer[dx[7:4]] : 5'd31;
            in_box_d1      <= in_box;
            pix_data_in_d1 <= pix_data_in;
            if (in_box_d1 && (glyph_letter <= 5'd25) && glyph_bit && visible)
                pix_data <= FG_COLOR;
            else
                pix_data <= pix_data_in_d1;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst)
            blink_cnt <= 5'd0;
        else if (frame_start)
            blink_cnt <= blink_cnt + 5'd1;
    end

    // Buffer writes and the clear sequencer share one block so a clear request
    // always takes priority over a coincident character write.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            clr_cnt  <= 4'd0;
            clr_done <= 1'b0;
            for (int i = 0; i < 16; i++)
                buffer[i] <= 5'd31;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= 4'd0;
                    end else if (wr_en) begin
                        buffer[wr_addr] <= wr_char;
                    end
                end
                CLEAR: begin
                    buffer[clr_cnt] <= 5'd31;
                    clr_cnt         <= clr_cnt + 4'd1;
                    if (clr_cnt == 4'd15) begin
                        state    <= DONE;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: rendering, box bounds, clear FSM, blinking,
// reset behaviour and back-to-back pipeline latency.
module tb_text_overlay;

    localparam logic [9:0]  X0 = 10'd40;
    localparam logic [9:0]  Y0 = 10'd20;
    localparam logic [15:0] FG = 16'hFFFF;

    logic        vga_clk = 1'b0;
    logic        sys_rst;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_data_in;
    logic        frame_start;
    logic        blink_en;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_char;
    logic        clr_req;
    logic        clr_done;
    logic [4:0]  glyph_letter;
    logic [3:0]  glyph_x;
    logic [3:0]  glyph_y;
    logic        glyph_bit;
    logic [15:0] pix_data;

    int checks = 0;
    int errors = 0;

    text_overlay #(.TEXT_X0(X0), .TEXT_Y0(Y0), .FG_COLOR(FG)) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data_in(pix_data_in), .frame_start(frame_start), .blink_en(blink_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .clr_req(clr_req),
        .clr_done(clr_done), .glyph_letter(glyph_letter), .glyph_x(glyph_x),
        .glyph_y(glyph_y), .glyph_bit(glyph_bit), .pix_data(pix_data)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic write_slot(input logic [3:0] a, input logic [4:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick();
        wr_en = 1'b0;
    endtask

    // Presents one pixel and returns stage-1 outputs after 1 edge, pix_data after 2.
    task automatic render(input logic [9:0] x, input logic [9:0] y, input logic [15:0] bg,
                          output logic [4:0] letter, output logic [3:0] gx,
                          output logic [3:0] gy, output logic [15:0] pix);
        pix_x = x; pix_y = y; pix_data_in = bg;
        tick();
        letter = glyph_letter; gx = glyph_x; gy = glyph_y;
        tick();
        pix = pix_data;
    endtask

    task automatic read_slot(input int s, output logic [4:0] v);
        pix_x = X0 + 10'(s * 16); pix_y = Y0;
        tick();
        v = glyph_letter;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        pix_x = X0 + 10'd3; pix_y = Y0 + 10'd5; pix_data_in = 16'hFFFF; glyph_bit = 1'b1;
        repeat (3) tick();
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pix got %h want 0000", pix_data); end
        checks++; if (glyph_letter !== 5'd31) begin errors++; $display("[TB] FAIL reset_letter got %0d want 31", glyph_letter); end
        checks++; if (glyph_x !== 4'd0 || glyph_y !== 4'd0) begin errors++; $display("[TB] FAIL reset_gxy got %0d/%0d want 0/0", glyph_x, glyph_y); end
        checks++; if (clr_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_clr_done got %b want 0", clr_done); end
        pix_x = 10'd0; pix_y = 10'd0; pix_data_in = 16'h00AA;
        sys_rst = 1'b0;
        tick();
        checks++; if (pix_data !== 16'h0000) begin errors++; $display("[TB] FAIL release_lat1 got %h want 0000", pix_data); end
        tick();
        checks++; if (pix_data !== 16'h00AA) begin errors++; $display("[TB] FAIL release_lat2 got %h want 00aa", pix_data); end
    endtask

    task automatic test_write_render();
        logic [4:0] l; logic [3:0] gx, gy; logic [15:0] p;
        write_slot(4'd0, 5'd0);
        glyph_bit = 1'b1;
        render(X0 + 10'd3, Y0 + 10'd5, 16'h0F0F, l, gx, gy, p);
        checks++; if (l !== 5'd0) begin errors++; $display("[TB] FAIL render_letter got %0d want 0", l); end
        checks++; if (gx !== 4'd3 || gy !== 4'd5) begin errors++; $display("[TB] FAIL render_gxy got %0d/%0d want 3/5", gx, gy); end
        checks++; if (p !== FG) begin errors++; $display("[TB] FAIL render_lit got %h want %h", p, FG); end
        glyph_bit = 1'b0;
        render(X0 + 10'd3, Y0 + 10'd5, 16'h0F0F, l, gx, gy, p);
        checks++; if (p !== 16'h0F0F) begin errors++; $display("[TB] FAIL render_unlit got %h want 0f0f", p); end
    endtask

    task automatic test_outside();
        logic [4:0] l; logic [3:0] gx, gy; logic [15:0] p;
        glyph_bit = 1'b1;
        render(X0 + 10'd256, Y0, 16'h1234, l, gx, gy, p);
        checks++; if (l !== 5'd31) begin errors++; $display("[TB] FAIL right_edge_letter got %0d want 31", l); end
        checks++; if (p !== 16'h1234) begin errors++; $display("[TB] FAIL right_edge_pix got %h want 1234", p); end
        render(X0 - 10'd1, Y0, 16'h2345, l, gx, gy, p);
        checks++; if (l !== 5'd31 || p !== 16'h2345) begin errors++; $display("[TB] FAIL left_underflow got %0d/%h want 31/2345", l, p); end
        render(X0, Y0 + 10'd16, 16'h3456, l, gx, gy, p);
        checks++; if (l !== 5'd31 || p !== 16'h3456) begin errors++; $display("[TB] FAIL below_box got %0d/%h want 31/3456", l, p); end
        render(X0, Y0 - 10'd1, 16'h4567, l, gx, gy, p);
        checks++; if (l !== 5'd31 || p !== 16'h4567) begin errors++; $display("[TB] FAIL above_box got %0d/%h want 31/4567", l, p); end
    endtask

    task automatic test_blank_char();
        logic [4:0] l; logic [3:0] gx, gy; logic [15:0] p;
        glyph_bit = 1'b1;
        write_slot(4'd2, 5'd27);
        render(X0 + 10'd37, Y0 + 10'd2, 16'hABCD, l, gx, gy, p);
        checks++; if (l !== 5'd27 || p !== 16'hABCD) begin errors++; $display("[TB] FAIL blank27 got %0d/%h want 27/abcd", l, p); end
        write_slot(4'd4, 5'd25);
        render(X0 + 10'd64, Y0, 16'h1357, l, gx, gy, p);
        checks++; if (l !== 5'd25 || p !== FG) begin errors++; $display("[TB] FAIL letter25 got %0d/%h want 25/%h", l, p, FG); end
        write_slot(4'd4, 5'd26);
        render(X0 + 10'd64, Y0, 16'h1357, l, gx, gy, p);
        checks++; if (l !== 5'd26 || p !== 16'h1357) begin errors++; $display("[TB] FAIL blank26 got %0d/%h want 26/1357", l, p); end
    endtask

    task automatic pulse_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; tick();
            frame_start = 1'b0; tick();
        end
    endtask

    task automatic test_blink();
        logic [4:0] l; logic [3:0] gx, gy; logic [15:0] p;
        glyph_bit = 1'b1; blink_en = 1'b1;
        pulse_frames(15);
        render(X0 + 10'd1, Y0 + 10'd1, 16'h0707, l, gx, gy, p);
        checks++; if (p !== FG) begin errors++; $display("[TB] FAIL blink_15 got %h want %h", p, FG); end
        pulse_frames(1);
        render(X0 + 10'd1, Y0 + 10'd1, 16'h0707, l, gx, gy, p);
        checks++; if (p !== 16'h0707) begin errors++; $display("[TB] FAIL blink_16_off got %h want 0707", p); end
        blink_en = 1'b0;
        render(X0 + 10'd1, Y0 + 10'd1, 16'h0707, l, gx, gy, p);
        checks++; if (p !== FG) begin errors++; $display("[TB] FAIL blink_disabled got %h want %h", p, FG); end
        blink_en = 1'b1;
        pulse_frames(15);
        render(X0 + 10'd1, Y0 + 10'd1, 16'h0707, l, gx, gy, p);
        checks++; if (p !== 16'h0707) begin errors++; $display("[TB] FAIL blink_31_off got %h want 0707", p); end
        pulse_frames(1);
        render(X0 + 10'd1, Y0 + 10'd1, 16'h0707, l, gx, gy, p);
        checks++; if (p !== FG) begin errors++; $display("[TB] FAIL blink_wrap got %h want %h", p, FG); end
        blink_en = 1'b0;
    endtask

    task automatic test_clear();
        logic [4:0] v;
        int n;
        int bad;
        write_slot(4'd1, 5'd1);
        write_slot(4'd15, 5'd7);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_char = 5'd4;
        tick();
        clr_req = 1'b0; wr_en = 1'b0;
        n = 1;
        while (n < 40) begin
            if (n == 5) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_char = 5'd2; clr_req = 1'b1;
            end else begin
                wr_en = 1'b0; clr_req = 1'b0;
            end
            tick();
            n++;
            if (clr_done === 1'b1) break;
        end
        wr_en = 1'b0; clr_req = 1'b0;
        checks++; if (n !== 17) begin errors++; $display("[TB] FAIL clr_done_cycle got %0d want 17", n); end
        tick();
        checks++; if (clr_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_done_width got %b want 0", clr_done); end
        bad = 0;
        for (int s = 0; s < 16; s++) begin
            read_slot(s, v);
            if (v !== 5'd31) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clear_slots got %0d non-blank slots want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  xs [4];
        logic [15:0] bgs [4];
        logic [15:0] exp [4];
        write_slot(4'd15, 5'd25);
        glyph_bit = 1'b1;
        xs[0] = X0 + 10'd254; xs[1] = X0 + 10'd255; xs[2] = X0 + 10'd256; xs[3] = X0 + 10'd257;
        bgs[0] = 16'h1111; bgs[1] = 16'h2222; bgs[2] = 16'h3333; bgs[3] = 16'h4444;
        exp[0] = FG; exp[1] = FG; exp[2] = 16'h3333; exp[3] = 16'h4444;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                pix_x = xs[i]; pix_y = Y0 + 10'd15; pix_data_in = bgs[i];
            end
            tick();
            if (i >= 1) begin
                checks++;
                if (pix_data !== exp[i-1]) begin
                    errors++;
                    $display("[TB] FAIL stream_%0d got %h want %h", i - 1, pix_data, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [4:0] v;
        int seen;
        int bad;
        write_slot(4'd5, 5'd9);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (7) tick();
        #2 sys_rst = 1'b1;
        #1;
        checks++; if (clr_done !== 1'b0 || glyph_letter !== 5'd31) begin errors++; $display("[TB] FAIL abort_async got %b/%0d want 0/31", clr_done, glyph_letter); end
        tick(); tick();
        sys_rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (clr_done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d pulses want 0", seen); end
        bad = 0;
        for (int s = 0; s < 16; s++) begin
            read_slot(s, v);
            if (v !== 5'd31) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL abort_slots got %0d non-blank slots want 0", bad); end
        write_slot(4'd2, 5'd3);
        read_slot(2, v);
        checks++; if (v !== 5'd3) begin errors++; $display("[TB] FAIL abort_write got %0d want 3", v); end
    endtask

    initial begin
        sys_rst = 1'b1; pix_x = 10'd0; pix_y = 10'd0; pix_data_in = 16'h0000;
        frame_start = 1'b0; blink_en = 1'b0; wr_en = 1'b0; wr_addr = 4'd0;
        wr_char = 5'd0; clr_req = 1'b0; glyph_bit = 1'b0;
        test_reset();
        test_write_render();
        test_outside();
        test_blank_char();
        test_blink();
        test_clear();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay.md
TEXT_OVERLAY -- requirements
Module: text_overlay

Interface
REQ-001 SHALL have parameter TEXT_X0, default 10'd0: left pixel column of the text box.
REQ-002 SHALL have parameter TEXT_Y0, default 10'd0: top pixel row of the text box.
REQ-003 SHALL have parameter FG_COLOR, default 16'hFFFF: RGB565 colour of lit glyph pixels.
REQ-004 vga_clk  input  1  pixel clock; all registers rise-edge on it.
REQ-005 sys_rst  input  1  reset, asynchronous and active-high.
REQ-006 pix_x  input  10  current pixel column from VGA timing.
REQ-007 pix_y  input  10  current pixel row from VGA timing.
REQ-008 pix_data_in  input  16  background RGB565 pixel aligned with pix_x/pix_y.
REQ-009 frame_start  input  1  one-cycle pulse at start of each frame.
REQ-010 blink_en  input  1  enables text blinking.
REQ-011 wr_en  input  1  character write strobe.
REQ-012 wr_addr  input  4  character slot 0..15.
REQ-013 wr_char  input  5  letter code: 0..25 = A..Z; any other value = blank.
REQ-014 clr_req  input  1  request to blank all 16 slots.
REQ-015 clr_done  output  1  one-cycle pulse when a clear completes.
REQ-016 glyph_letter  output  5  letter code sent to the glyph ROM.
REQ-017 glyph_x  output  4  column within the 16x16 glyph.
REQ-018 glyph_y  output  4  row within the 16x16 glyph.
REQ-019 glyph_bit  input  1  combinational glyph ROM result for the current glyph_* values.
REQ-020 pix_data  output  16  composited RGB565 pixel.

Function
REQ-021 SHALL hold a 16-entry x 5-bit message buffer in flops.
REQ-022 Text box: TEXT_X0 <= pix_x < TEXT_X0+256 and TEXT_Y0 <= pix_y < TEXT_Y0+16.
REQ-023 Stage 1 SHALL register the following each cycle:
- dx = pix_x-TEXT_X0 and dy = pix_y-TEXT_Y0;
- glyph_x = dx[3:0] and glyph_y = dy[3:0];
- glyph_letter = buffer[dx[7:4]];
- in_box;
- pix_data_in.
REQ-024 Stage 2 SHALL register the following each cycle:
- pix_data = FG_COLOR when all of in_box_d1, glyph_letter<=25, glyph_bit and visible are 1;
- otherwise pix_data = pix_data_in_d1.
REQ-025 Latency from pix_x/pix_y/pix_data_in to pix_data SHALL be exactly 2 cycles, with no stalls.
REQ-026 Outside the box, glyph_letter SHALL be driven 5'd31.
REQ-027 Blink counter (5 bits) SHALL increment on each frame_start and wrap from 31 to 0.
REQ-028 visible SHALL be 1 when blink_en=0; otherwise visible = ~blink_cnt[4] (16 frames on, 16 frames off).
REQ-029 In IDLE, wr_en SHALL write wr_char into buffer[wr_addr] on the clock edge; the new value is visible to stage 1 from the next cycle.
REQ-030 Clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-031 FSM transitions SHALL be:
- IDLE -> CLEAR on clr_req;
- CLEAR writes 5'd31 to slot clr_cnt, clr_cnt counting 0..15 over 16 cycles;
- CLEAR -> DONE after slot 15;
- DONE asserts clr_done for 1 cycle, then -> IDLE.
REQ-032 If clr_req and wr_en are both asserted in IDLE, clr_req SHALL win and the write is discarded.
REQ-033 In CLEAR and DONE, wr_en and clr_req SHALL be ignored.
REQ-034 The rendering pipeline SHALL keep running during a clear; partially cleared text displays as is.
REQ-035 Subtractions SHALL be 10-bit; an underflow (pix_x<TEXT_X0) SHALL be excluded by the in_box compare, not by the wrapped value.

Reset
REQ-036 On sys_rst, every buffer entry SHALL be set to 5'd31.
REQ-037 On sys_rst, the FSM SHALL go to IDLE with clr_cnt=0, blink_cnt=0, clr_done=0.
REQ-038 On sys_rst, pipeline registers SHALL be zeroed: pix_data=16'h0000, glyph_x=0, glyph_y=0, glyph_letter=5'd31.
REQ-039 Reset asserted during CLEAR SHALL abort the clear; no clr_done pulse is issued.
REQ-040 After release, the first valid pix_data SHALL appear 2 cycles after the first sampled pixel.

Verification
REQ-041 Write wr_addr=0, wr_char=0 ('A'); drive pix_x=TEXT_X0+3, pix_y=TEXT_Y0+5 -> next cycle glyph_letter=0, glyph_x=3, glyph_y=5; with glyph_bit=1, pix_data=16'hFFFF two cycles after the pixel.
REQ-042 Drive pix_x=TEXT_X0+256, pix_data_in=16'h1234, glyph_bit=1 -> glyph_letter=31 and pix_data=16'h1234 after 2 cycles.
REQ-043 Pulse clr_req with wr_en=1 in the same cycle -> 16 CLEAR cycles, clr_done high exactly on cycle 17, all slots read as 31, and the coincident write is absent.
REQ-044 Set blink_en=1 and issue 16 frame_start pulses -> lit pixels show background; after 16 more pulses -> FG_COLOR again; after 32 total pulses blink_cnt wraps to 0.
REQ-045 Assert sys_rst at CLEAR cycle 8 -> clr_done never pulses, all slots read 31, FSM is in IDLE; a subsequent wr_en is accepted.
REQ-046 Write wr_char=27 to slot 2 and render within slot 2 with glyph_bit=1 -> pix_data equals the background.
